// File: rtl/mux4to1_pkg.sv
// Shared types and constants for the 4-to-1 round-robin collector.
package mux4to1_pkg;

  localparam int unsigned NUM_CH = 4;

  typedef logic [1:0] ch_idx_t;

  // Pointer value that gives channel A top priority after reset
  localparam ch_idx_t LG_RESET = 2'b11;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin arbiter; the caller owns the last-grant pointer.
module rr_arbiter4
  import mux4to1_pkg::*;
(
  input  logic [NUM_CH-1:0] req_i,
  input  ch_idx_t           lg_i,
  input  logic              en_i,
  output logic [NUM_CH-1:0] gnt_o,
  output ch_idx_t           gnt_idx_o,
  output logic              any_req_o
);

  ch_idx_t idx_c;
  logic    found_c;

  assign any_req_o = |req_i;

  // Search starts one past the last grant and wraps, ending on the last grant itself
  always_comb begin
    gnt_idx_o = lg_i;
    idx_c     = lg_i;
    found_c   = 1'b0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      idx_c = lg_i + ch_idx_t'(k);
      if (!found_c && req_i[idx_c]) begin
        gnt_idx_o = idx_c;
        found_c   = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_o = 4'b0000;
    if (en_i && any_req_o) begin
      gnt_o = 4'b0001 << gnt_idx_o;
    end
  end

endmodule

// File: rtl/mux4to1_rr_collector.sv
// Merges four valid/ready channels into one registered stream tagged with the source index.
module mux4to1_rr_collector
  import mux4to1_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  A,
  input  logic [N-1:0]  B,
  input  logic [N-1:0]  C,
  input  logic [N-1:0]  D,
  input  logic [3:0]    vld,
  output logic [3:0]    rdy,
  output logic [N-1:0]  O,
  output logic [1:0]    sel,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [CW-1:0] beats
);

  state_e        state_q, state_d;
  logic [N-1:0]  o_q, o_d;
  ch_idx_t       sel_q, sel_d;
  ch_idx_t       lg_q, lg_d;
  logic [CW-1:0] beats_q, beats_d;

  logic          ld_c;
  logic          xfer_c;
  logic          any_req_c;
  ch_idx_t       gnt_idx_c;
  logic [3:0]    gnt_c;
  logic [N-1:0]  data_c;

  // Output slot can take a new beat when empty or when the current beat is leaving
  assign ld_c   = (state_q == EMPTY) | o_rdy;
  assign xfer_c = ld_c & any_req_c;

  rr_arbiter4 u_arb (
    .req_i     (vld),
    .lg_i      (lg_q),
    .en_i      (ld_c),
    .gnt_o     (gnt_c),
    .gnt_idx_o (gnt_idx_c),
    .any_req_o (any_req_c)
  );

  always_comb begin
    data_c = A;
    case (gnt_idx_c)
      2'd0:    data_c = A;
      2'd1:    data_c = B;
      2'd2:    data_c = C;
      default: data_c = D;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      o_q     <= '0;
      sel_q   <= 2'b00;
      lg_q    <= LG_RESET;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
      sel_q   <= sel_d;
      lg_q    <= lg_d;
      beats_q <= beats_d;
    end
  end

  // Next-state and datapath update; a drain with no request keeps O/sel/lg untouched
  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    sel_d   = sel_q;
    lg_d    = lg_q;
    beats_d = beats_q;
    case (state_q)
      EMPTY: begin
        if (any_req_c) state_d = FULL;
      end
      FULL: begin
        if (o_rdy && !any_req_c) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    if (xfer_c) begin
      o_d     = data_c;
      sel_d   = gnt_idx_c;
      lg_d    = gnt_idx_c;
      beats_d = beats_q + CW'(1);
    end
  end

  assign rdy   = gnt_c;
  assign O     = o_q;
  assign sel   = sel_q;
  assign o_vld = (state_q == FULL);
  assign beats = beats_q;

endmodule

// File: tb/tb_mux4to1_rr_collector.sv
// Directed self-checking bench for the round-robin collector (CW=8 and CW=2 instances).
module tb_mux4to1_rr_collector;

  logic       clk;
  logic       rst_n;
  logic [3:0] A, B, C, D;
  logic [3:0] vld;
  logic       o_rdy;

  logic [3:0] rdy, rdy2;
  logic [3:0] O, O2;
  logic [1:0] sel, sel2;
  logic       o_vld, o_vld2;
  logic [7:0] beats;
  logic [1:0] beats2;

  int checks;
  int failures;

  mux4to1_rr_collector #(.N(4), .CW(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .D(D), .vld(vld),
    .rdy(rdy), .O(O), .sel(sel), .o_vld(o_vld), .o_rdy(o_rdy), .beats(beats)
  );

  mux4to1_rr_collector #(.N(4), .CW(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .D(D), .vld(vld),
    .rdy(rdy2), .O(O2), .sel(sel2), .o_vld(o_vld2), .o_rdy(o_rdy), .beats(beats2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    vld   = 4'b0000;
    o_rdy = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vld = 4'b0000; o_rdy = 1'b0;
    A = 4'h1; B = 4'h2; C = 4'h4; D = 4'h8;
    tick(); tick();
    checks++;
    if ({O, sel, o_vld, beats} !== {4'h0, 2'b00, 1'b0, 8'd0}) begin
      failures++;
      $display("FAIL reset_hold got O=%h sel=%b o_vld=%b beats=%0d exp 0/00/0/0", O, sel, o_vld, beats);
    end
    rst_n = 1'b1; vld = 4'b1111; o_rdy = 1'b1;
    tick(); tick();
    checks++;
    if ({o_vld, sel} !== {1'b1, 2'b01}) begin
      failures++;
      $display("FAIL reset_prestream got o_vld=%b sel=%b exp 1/01", o_vld, sel);
    end
    rst_n = 1'b0; vld = 4'b0000;
    #1;
    checks++;
    if ({O, sel, o_vld, beats, rdy} !== {4'h0, 2'b00, 1'b0, 8'd0, 4'b0000}) begin
      failures++;
      $display("FAIL reset_midstream got O=%h sel=%b o_vld=%b beats=%0d rdy=%b exp 0/00/0/0/0000",
               O, sel, o_vld, beats, rdy);
    end
    tick();
    rst_n = 1'b1; vld = 4'b1111;
    #1;
    checks++;
    if (rdy !== 4'b0001) begin
      failures++;
      $display("FAIL reset_first_rdy got %b exp 0001", rdy);
    end
    tick();
    checks++;
    if ({o_vld, sel, O, beats} !== {1'b1, 2'b00, 4'h1, 8'd1}) begin
      failures++;
      $display("FAIL reset_first_grant got o_vld=%b sel=%b O=%h beats=%0d exp 1/00/1/1", o_vld, sel, O, beats);
    end
    vld = 4'b0000;
  endtask

  task automatic test_single();
    do_reset();
    B = 4'hA; vld = 4'b0010; o_rdy = 1'b1;
    #1;
    checks++;
    if (rdy !== 4'b0010) begin
      failures++;
      $display("FAIL single_rdy got %b exp 0010", rdy);
    end
    tick();
    checks++;
    if ({O, sel, o_vld, beats} !== {4'hA, 2'b01, 1'b1, 8'd1}) begin
      failures++;
      $display("FAIL single_beat got O=%h sel=%b o_vld=%b beats=%0d exp A/01/1/1", O, sel, o_vld, beats);
    end
    vld = 4'b0000;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_sel [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    logic [3:0] exp_o   [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    do_reset();
    A = 4'h1; B = 4'h2; C = 4'h4; D = 4'h8;
    vld = 4'b1111; o_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({o_vld, sel, O} !== {1'b1, exp_sel[i], exp_o[i]}) begin
        failures++;
        $display("FAIL rr_beat%0d got o_vld=%b sel=%b O=%h exp 1/%b/%h", i, o_vld, sel, O, exp_sel[i], exp_o[i]);
      end
    end
    checks++;
    if (beats !== 8'd5) begin
      failures++;
      $display("FAIL rr_beats got %0d exp 5", beats);
    end
    vld = 4'b0000;
  endtask

  task automatic test_backpressure();
    do_reset();
    A = 4'h1; B = 4'h2; C = 4'h4; D = 4'h8;
    vld = 4'b1111; o_rdy = 1'b1;
    tick(); tick(); tick();
    o_rdy = 1'b0;
    #1;
    checks++;
    if (rdy !== 4'b0000) begin
      failures++;
      $display("FAIL bp_rdy got %b exp 0000", rdy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({o_vld, sel, O, beats, rdy} !== {1'b1, 2'b10, 4'h4, 8'd3, 4'b0000}) begin
        failures++;
        $display("FAIL bp_hold%0d got o_vld=%b sel=%b O=%h beats=%0d rdy=%b exp 1/10/4/3/0000",
                 i, o_vld, sel, O, beats, rdy);
      end
    end
    o_rdy = 1'b1;
    tick();
    checks++;
    if ({o_vld, sel, O, beats} !== {1'b1, 2'b11, 4'h8, 8'd4}) begin
      failures++;
      $display("FAIL bp_release got o_vld=%b sel=%b O=%h beats=%0d exp 1/11/8/4", o_vld, sel, O, beats);
    end
    vld = 4'b0000;
  endtask

  task automatic test_skip_idle();
    logic [1:0] exp_sel [4] = '{2'b11, 2'b01, 2'b11, 2'b01};
    logic [3:0] exp_o   [4] = '{4'h8, 4'h2, 4'h8, 4'h2};
    do_reset();
    A = 4'h1; B = 4'h2; C = 4'h4; D = 4'h8;
    vld = 4'b0010; o_rdy = 1'b1;
    tick();
    vld = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({o_vld, sel, O} !== {1'b1, exp_sel[i], exp_o[i]}) begin
        failures++;
        $display("FAIL skip_beat%0d got o_vld=%b sel=%b O=%h exp 1/%b/%h", i, o_vld, sel, O, exp_sel[i], exp_o[i]);
      end
    end
    vld = 4'b0000;
  endtask

  task automatic test_wrap();
    logic [1:0] exp_b [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    A = 4'h5; o_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vld = 4'b0001;
      tick();
      vld = 4'b0000;
      checks++;
      if ({o_vld2, beats2} !== {1'b1, exp_b[i]}) begin
        failures++;
        $display("FAIL wrap_beat%0d got o_vld=%b beats=%0d exp 1/%0d", i, o_vld2, beats2, exp_b[i]);
      end
      tick();
    end
    checks++;
    if ({o_vld2, beats2} !== {1'b0, 2'd1}) begin
      failures++;
      $display("FAIL wrap_drain got o_vld=%b beats=%0d exp 0/1", o_vld2, beats2);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n = 1'b0; vld = 4'b0000; o_rdy = 1'b0;
    A = 4'h0; B = 4'h0; C = 4'h0; D = 4'h0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_skip_idle();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
